// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: owns the PC and fetches from instruction memory
// over a req/ack handshake. It feeds the IF/ID register with the fetched word,
// its PC+4, a load enable and a clear. While decode is stalled it buffers one
// word. On a taken branch it flushes IF/ID and discards any fetch in flight.
// Optional build macro FETCH_PERF_CNT_EN adds the saturating Fetch_Count and
// Flush_Count outputs.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        Stall,
  input  logic        Branch_Taken,
  input  logic [31:0] Branch_Target,
  output logic        Mem_Req,
  output logic [31:0] Mem_Addr,
  input  logic [31:0] Mem_Data,
  input  logic        Mem_Ack,
  output logic [31:0] Instr_Out,
  output logic [31:0] PC4_Out,
  output logic        LE_Out,
  output logic        Flush_Out,
  output logic [31:0] PC_Out
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] Fetch_Count,
  output logic [31:0] Flush_Count
`endif
);

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        le_q, le_d;
  logic        flush_q, flush_d;
  // The hold buffer is only meaningful while in ST_HOLD; leaving HOLD
  // (delivery or redirect) is what invalidates it.
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc4_q, buf_pc4_d;

  logic        ack;
  logic [31:0] pc_plus4;
  logic [31:0] branch_pc;
  logic        unused_target_bits;

  // An ack only counts against an outstanding request.
  assign ack                = Mem_Ack & req_q;
  assign pc_plus4           = pc_q + 32'd4;
  assign branch_pc          = {Branch_Target[31:2], 2'b00};
  assign unused_target_bits = ^Branch_Target[1:0];

  // Next-state and next-output logic; Branch_Taken outranks Stall and Ack.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_d       = req_q;
    addr_d      = addr_q;
    instr_d     = instr_q;
    pc4_d       = pc4_q;
    le_d        = 1'b0;
    flush_d     = 1'b0;
    buf_instr_d = buf_instr_q;
    buf_pc4_d   = buf_pc4_q;

    case (state_q)
      ST_REQ: begin
        if (Branch_Taken) begin
          pc_d    = branch_pc;
          flush_d = 1'b1;
          if (ack || !req_q) begin
            // Nothing left outstanding: go straight to the new target.
            req_d   = 1'b1;
            addr_d  = branch_pc;
            state_d = ST_REQ;
          end else begin
            // Request still open: keep it stable and swallow its data later.
            state_d = ST_DRAIN;
          end
        end else if (!req_q) begin
          // First cycle after reset: raise the request at the current PC.
          req_d  = 1'b1;
          addr_d = pc_q;
        end else if (ack) begin
          pc_d = pc_plus4;
          if (Stall) begin
            buf_instr_d = Mem_Data;
            buf_pc4_d   = pc_plus4;
            req_d       = 1'b0;
            state_d     = ST_HOLD;
          end else begin
            instr_d = Mem_Data;
            pc4_d   = pc_plus4;
            le_d    = 1'b1;
            addr_d  = pc_plus4;
          end
        end
      end

      ST_HOLD: begin
        if (Branch_Taken) begin
          pc_d    = branch_pc;
          flush_d = 1'b1;
          req_d   = 1'b1;
          addr_d  = branch_pc;
          state_d = ST_REQ;
        end else if (!Stall) begin
          // Deliver the buffered word and issue the next request together.
          instr_d = buf_instr_q;
          pc4_d   = buf_pc4_q;
          le_d    = 1'b1;
          req_d   = 1'b1;
          addr_d  = pc_q;
          state_d = ST_REQ;
        end
      end

      ST_DRAIN: begin
        if (Branch_Taken) begin
          pc_d    = branch_pc;
          flush_d = 1'b1;
          if (ack) begin
            // The stale request completed in the same cycle; it is done.
            addr_d  = branch_pc;
            state_d = ST_REQ;
          end
        end else if (ack) begin
          // Stale data is dropped; restart at the redirected PC.
          addr_d  = pc_q;
          state_d = ST_REQ;
        end
      end

      default: begin
        state_d = ST_REQ;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by CLR.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q     <= ST_REQ;
      pc_q        <= RESET_PC;
      req_q       <= 1'b0;
      addr_q      <= RESET_PC;
      instr_q     <= 32'd0;
      pc4_q       <= 32'd0;
      le_q        <= 1'b0;
      flush_q     <= 1'b0;
      buf_instr_q <= 32'd0;
      buf_pc4_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      instr_q     <= instr_d;
      pc4_q       <= pc4_d;
      le_q        <= le_d;
      flush_q     <= flush_d;
      buf_instr_q <= buf_instr_d;
      buf_pc4_q   <= buf_pc4_d;
    end
  end

  assign Mem_Req   = req_q;
  assign Mem_Addr  = addr_q;
  assign Instr_Out = instr_q;
  assign PC4_Out   = pc4_q;
  assign LE_Out    = le_q;
  assign Flush_Out = flush_q;
  assign PC_Out    = pc_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Saturating counters of IF/ID loads and IF/ID flushes.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (le_q && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
    if (flush_q && (flush_cnt_q != 32'hFFFF_FFFF)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  // Counter registers, cleared with the rest of the unit.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      fetch_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign Fetch_Count = fetch_cnt_q;
  assign Flush_Count = flush_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus a
// randomized run scored against a program-order model of the fetch stream.
module tb_instruction_fetch_unit;

  logic        CLK;
  logic        CLR;
  logic        Stall;
  logic        Branch_Taken;
  logic [31:0] Branch_Target;
  logic        Mem_Req;
  logic [31:0] Mem_Addr;
  logic [31:0] Mem_Data;
  logic        Mem_Ack;
  logic [31:0] Instr_Out;
  logic [31:0] PC4_Out;
  logic        LE_Out;
  logic        Flush_Out;
  logic [31:0] PC_Out;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] Fetch_Count;
  logic [31:0] Flush_Count;
`endif

  int n_asserts = 0;
  int n_fail    = 0;

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .CLK           (CLK),
    .CLR           (CLR),
    .Stall         (Stall),
    .Branch_Taken  (Branch_Taken),
    .Branch_Target (Branch_Target),
    .Mem_Req       (Mem_Req),
    .Mem_Addr      (Mem_Addr),
    .Mem_Data      (Mem_Data),
    .Mem_Ack       (Mem_Ack),
    .Instr_Out     (Instr_Out),
    .PC4_Out       (PC4_Out),
    .LE_Out        (LE_Out),
    .Flush_Out     (Flush_Out),
    .PC_Out        (PC_Out)
`ifdef FETCH_PERF_CNT_EN
    ,
    .Fetch_Count   (Fetch_Count),
    .Flush_Count   (Flush_Count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory contents: a scrambled function of the address.
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  // One clock: outputs are examined 1 time unit after the edge, and memory
  // presents the word at the (possibly new) request address.
  task automatic step();
    @(posedge CLK);
    #1;
    Mem_Data = word_of(Mem_Addr);
  endtask

  task automatic do_reset();
    CLR = 1'b0; Stall = 1'b0; Branch_Taken = 1'b0; Branch_Target = 32'd0;
    Mem_Ack = 1'b0; Mem_Data = 32'd0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    CLR = 1'b1;
    Mem_Data = word_of(Mem_Addr);
  endtask

  task automatic test_reset();
    CLR = 1'b0; Stall = 1'b0; Branch_Taken = 1'b0; Branch_Target = 32'd0;
    Mem_Ack = 1'b1; Mem_Data = 32'hFFFF_FFFF;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    n_asserts++; if (Mem_Req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", Mem_Req); end
    n_asserts++; if (Mem_Addr !== 32'd0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", Mem_Addr); end
    n_asserts++; if (Instr_Out !== 32'd0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", Instr_Out); end
    n_asserts++; if (PC4_Out !== 32'd0) begin n_fail++; $display("FAIL reset_pc4: got %h want 0", PC4_Out); end
    n_asserts++; if (LE_Out !== 1'b0) begin n_fail++; $display("FAIL reset_le: got %b want 0", LE_Out); end
    n_asserts++; if (Flush_Out !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %b want 0", Flush_Out); end
    n_asserts++; if (PC_Out !== 32'd0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", PC_Out); end
    CLR = 1'b1;
    Mem_Ack = 1'b0;
    step();
    n_asserts++; if (Mem_Req !== 1'b1) begin n_fail++; $display("FAIL reset_first_req: got %b want 1", Mem_Req); end
    $display("test_reset done");
  endtask

  task automatic test_streaming();
    do_reset();
    Mem_Ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_asserts++; if (Mem_Addr !== 32'(4 * i)) begin n_fail++; $display("FAIL stream_addr[%0d]: got %h want %h", i, Mem_Addr, 32'(4 * i)); end
      if (i == 0) begin
        n_asserts++; if (LE_Out !== 1'b0) begin n_fail++; $display("FAIL stream_le0: got %b want 0", LE_Out); end
      end else begin
        n_asserts++; if (LE_Out !== 1'b1) begin n_fail++; $display("FAIL stream_le[%0d]: got %b want 1", i, LE_Out); end
        n_asserts++; if (PC4_Out !== 32'(4 * i)) begin n_fail++; $display("FAIL stream_pc4[%0d]: got %h want %h", i, PC4_Out, 32'(4 * i)); end
        n_asserts++; if (Instr_Out !== word_of(32'(4 * (i - 1)))) begin n_fail++; $display("FAIL stream_instr[%0d]: got %h want %h", i, Instr_Out, word_of(32'(4 * (i - 1)))); end
      end
    end
    $display("test_streaming done");
  endtask

  task automatic test_stall();
    do_reset();
    Mem_Ack = 1'b1;
    repeat (3) step();
    n_asserts++; if (Mem_Addr !== 32'h8) begin n_fail++; $display("FAIL stall_pre_addr: got %h want 8", Mem_Addr); end
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_asserts++; if (Mem_Req !== 1'b0) begin n_fail++; $display("FAIL stall_req[%0d]: got %b want 0", i, Mem_Req); end
      n_asserts++; if (LE_Out !== 1'b0) begin n_fail++; $display("FAIL stall_le[%0d]: got %b want 0", i, LE_Out); end
    end
    Stall = 1'b0;
    step();
    n_asserts++; if (LE_Out !== 1'b1) begin n_fail++; $display("FAIL stall_rel_le: got %b want 1", LE_Out); end
    n_asserts++; if (Instr_Out !== word_of(32'h8)) begin n_fail++; $display("FAIL stall_rel_instr: got %h want %h", Instr_Out, word_of(32'h8)); end
    n_asserts++; if (PC4_Out !== 32'hC) begin n_fail++; $display("FAIL stall_rel_pc4: got %h want c", PC4_Out); end
    n_asserts++; if (Mem_Req !== 1'b1 || Mem_Addr !== 32'hC) begin n_fail++; $display("FAIL stall_rel_addr: got req=%b addr=%h want req=1 addr=c", Mem_Req, Mem_Addr); end
    step();
    n_asserts++; if (LE_Out !== 1'b1 || Instr_Out !== word_of(32'hC) || PC4_Out !== 32'h10) begin n_fail++; $display("FAIL stall_next_word: got le=%b instr=%h pc4=%h want le=1 instr=%h pc4=10", LE_Out, Instr_Out, PC4_Out, word_of(32'hC)); end
    $display("test_stall done");
  endtask

  task automatic test_branch_pending();
    do_reset();
    Mem_Ack = 1'b1;
    repeat (9) step();
    n_asserts++; if (Mem_Addr !== 32'h20) begin n_fail++; $display("FAIL brp_pre_addr: got %h want 20", Mem_Addr); end
    Mem_Ack = 1'b0; Branch_Taken = 1'b1; Branch_Target = 32'h103;
    step();
    Branch_Taken = 1'b0;
    n_asserts++; if (Flush_Out !== 1'b1 || LE_Out !== 1'b0) begin n_fail++; $display("FAIL brp_flush: got flush=%b le=%b want flush=1 le=0", Flush_Out, LE_Out); end
    n_asserts++; if (Mem_Req !== 1'b1 || Mem_Addr !== 32'h20) begin n_fail++; $display("FAIL brp_hold1: got req=%b addr=%h want req=1 addr=20", Mem_Req, Mem_Addr); end
    n_asserts++; if (PC_Out !== 32'h100) begin n_fail++; $display("FAIL brp_pc: got %h want 100", PC_Out); end
    step();
    n_asserts++; if (Flush_Out !== 1'b0 || LE_Out !== 1'b0 || Mem_Addr !== 32'h20) begin n_fail++; $display("FAIL brp_hold2: got flush=%b le=%b addr=%h want 0 0 20", Flush_Out, LE_Out, Mem_Addr); end
    Mem_Ack = 1'b1;
    step();
    n_asserts++; if (LE_Out !== 1'b0 || Mem_Addr !== 32'h100) begin n_fail++; $display("FAIL brp_drain: got le=%b addr=%h want le=0 addr=100", LE_Out, Mem_Addr); end
    step();
    n_asserts++; if (LE_Out !== 1'b1 || PC4_Out !== 32'h104 || Instr_Out !== word_of(32'h100)) begin n_fail++; $display("FAIL brp_target_word: got le=%b pc4=%h instr=%h want 1 104 %h", LE_Out, PC4_Out, Instr_Out, word_of(32'h100)); end
    $display("test_branch_pending done");
  endtask

  task automatic test_branch_stall_ack();
    do_reset();
    Mem_Ack = 1'b1;
    repeat (4) step();
    Stall = 1'b1; Branch_Taken = 1'b1; Branch_Target = 32'h40;
    step();
    Stall = 1'b0; Branch_Taken = 1'b0;
    n_asserts++; if (Flush_Out !== 1'b1 || LE_Out !== 1'b0) begin n_fail++; $display("FAIL bsa_flush: got flush=%b le=%b want 1 0", Flush_Out, LE_Out); end
    n_asserts++; if (Mem_Req !== 1'b1 || Mem_Addr !== 32'h40) begin n_fail++; $display("FAIL bsa_addr: got req=%b addr=%h want 1 40", Mem_Req, Mem_Addr); end
    step();
    n_asserts++; if (LE_Out !== 1'b1 || Instr_Out !== word_of(32'h40) || PC4_Out !== 32'h44 || Flush_Out !== 1'b0) begin n_fail++; $display("FAIL bsa_next: got le=%b instr=%h pc4=%h flush=%b want 1 %h 44 0", LE_Out, Instr_Out, PC4_Out, Flush_Out, word_of(32'h40)); end
    $display("test_branch_stall_ack done");
  endtask

  task automatic test_wrap();
    do_reset();
    Mem_Ack = 1'b1;
    repeat (2) step();
    Branch_Taken = 1'b1; Branch_Target = 32'hFFFF_FFFE;
    step();
    Branch_Taken = 1'b0;
    n_asserts++; if (Mem_Addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr: got %h want fffffffc", Mem_Addr); end
    step();
    n_asserts++; if (LE_Out !== 1'b1 || PC4_Out !== 32'd0 || Instr_Out !== word_of(32'hFFFF_FFFC)) begin n_fail++; $display("FAIL wrap_pc4: got le=%b pc4=%h instr=%h want 1 0 %h", LE_Out, PC4_Out, Instr_Out, word_of(32'hFFFF_FFFC)); end
    n_asserts++; if (Mem_Addr !== 32'd0) begin n_fail++; $display("FAIL wrap_next_addr: got %h want 0", Mem_Addr); end
    step();
    n_asserts++; if (PC4_Out !== 32'h4 || Instr_Out !== word_of(32'd0)) begin n_fail++; $display("FAIL wrap_after: got pc4=%h instr=%h want 4 %h", PC4_Out, Instr_Out, word_of(32'd0)); end
    $display("test_wrap done");
  endtask

  task automatic test_reset_in_drain();
    do_reset();
    Mem_Ack = 1'b1;
    repeat (3) step();
    Mem_Ack = 1'b0; Branch_Taken = 1'b1; Branch_Target = 32'h200;
    step();
    Branch_Taken = 1'b0;
    n_asserts++; if (Mem_Req !== 1'b1 || Flush_Out !== 1'b1) begin n_fail++; $display("FAIL rid_drain: got req=%b flush=%b want 1 1", Mem_Req, Flush_Out); end
    #2;
    CLR = 1'b0;
    #1;
    n_asserts++; if (Mem_Req !== 1'b0 || Mem_Addr !== 32'd0) begin n_fail++; $display("FAIL rid_mem: got req=%b addr=%h want 0 0", Mem_Req, Mem_Addr); end
    n_asserts++; if (Instr_Out !== 32'd0 || PC4_Out !== 32'd0 || PC_Out !== 32'd0) begin n_fail++; $display("FAIL rid_data: got instr=%h pc4=%h pc=%h want 0 0 0", Instr_Out, PC4_Out, PC_Out); end
    n_asserts++; if (LE_Out !== 1'b0 || Flush_Out !== 1'b0) begin n_fail++; $display("FAIL rid_ctrl: got le=%b flush=%b want 0 0", LE_Out, Flush_Out); end
`ifdef FETCH_PERF_CNT_EN
    n_asserts++; if (Fetch_Count !== 32'd0 || Flush_Count !== 32'd0) begin n_fail++; $display("FAIL rid_counts: got fetch=%0d flush=%0d want 0 0", Fetch_Count, Flush_Count); end
`endif
    @(posedge CLK);
    #1;
    CLR = 1'b1;
    Mem_Ack = 1'b1;
    step();
    n_asserts++; if (Mem_Req !== 1'b1 || Mem_Addr !== 32'd0 || LE_Out !== 1'b0) begin n_fail++; $display("FAIL rid_restart: got req=%b addr=%h le=%b want 1 0 0", Mem_Req, Mem_Addr, LE_Out); end
    step();
    n_asserts++; if (LE_Out !== 1'b1 || PC4_Out !== 32'h4 || Instr_Out !== word_of(32'd0)) begin n_fail++; $display("FAIL rid_first_word: got le=%b pc4=%h instr=%h want 1 4 %h", LE_Out, PC4_Out, Instr_Out, word_of(32'd0)); end
    $display("test_reset_in_drain done");
  endtask

  // Random traffic scored at the level of the instruction stream: every
  // IF/ID load must carry the next word in program order (restarting at
  // the latest branch target), flushes mirror branches one cycle later,
  // open requests stay stable, and nothing loads while decode is stalled.
  task automatic test_random();
    logic [31:0] exp_next;
    logic        prev_req;
    logic [31:0] prev_addr;
    logic        s_stall, s_br, s_ack;
    logic [31:0] s_tgt;
    int          delivered;
    int          le_seen;
    int          fl_seen;
    do_reset();
    exp_next  = 32'h0;
    delivered = 0;
    le_seen   = 0;
    fl_seen   = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      s_stall = ($urandom_range(0, 9) < 3);
      s_br    = ($urandom_range(0, 24) == 0);
      s_ack   = ($urandom_range(0, 9) < 6);
      s_tgt   = (cyc % 7 == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      Stall = s_stall; Branch_Taken = s_br; Mem_Ack = s_ack; Branch_Target = s_tgt;
      prev_req  = Mem_Req;
      prev_addr = Mem_Addr;
      step();
      if (s_br) exp_next = s_tgt & ~32'd3;
      n_asserts++; if (Flush_Out !== s_br) begin n_fail++; $display("FAIL rnd_flush[%0d]: got %b want %b", cyc, Flush_Out, s_br); end
      n_asserts++; if (LE_Out === 1'b1 && Flush_Out === 1'b1) begin n_fail++; $display("FAIL rnd_le_flush[%0d]: got both 1 want exclusive", cyc); end
      if (prev_req && !s_ack) begin
        n_asserts++; if (Mem_Req !== 1'b1 || Mem_Addr !== prev_addr) begin n_fail++; $display("FAIL rnd_stable[%0d]: got req=%b addr=%h want 1 %h", cyc, Mem_Req, Mem_Addr, prev_addr); end
      end
`ifdef FETCH_PERF_CNT_EN
      n_asserts++; if (Fetch_Count !== 32'(le_seen) || Flush_Count !== 32'(fl_seen)) begin n_fail++; $display("FAIL rnd_counts[%0d]: got %0d %0d want %0d %0d", cyc, Fetch_Count, Flush_Count, le_seen, fl_seen); end
`endif
      if (LE_Out === 1'b1) begin
        n_asserts++; if (s_stall) begin n_fail++; $display("FAIL rnd_le_stall[%0d]: got le=1 want 0 while stalled", cyc); end
        n_asserts++; if (PC4_Out !== exp_next + 32'd4 || Instr_Out !== word_of(exp_next)) begin n_fail++; $display("FAIL rnd_order[%0d]: got pc4=%h instr=%h want %h %h", cyc, PC4_Out, Instr_Out, exp_next + 32'd4, word_of(exp_next)); end
        exp_next  = exp_next + 32'd4;
        delivered = delivered + 1;
        le_seen   = le_seen + 1;
      end
      if (Flush_Out === 1'b1) fl_seen = fl_seen + 1;
    end
    n_asserts++; if (delivered < 50) begin n_fail++; $display("FAIL rnd_progress: got %0d words want >= 50", delivered); end
    Stall = 1'b0; Branch_Taken = 1'b0; Mem_Ack = 1'b0;
    $display("test_random done: %0d words delivered", delivered);
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall();
    test_branch_pending();
    test_branch_stall_ack();
    test_wrap();
    test_reset_in_drain();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
